ps2_keypad_decoder: RTL and testbench

Consumes the byte stream produced by the PS/2 transceiver and turns PS/2 scan-code set 2 make/break sequences into a registered 8-bit NES controller button vector for the controller port. After reset it drives the transceiver's command interface once to reset the keyboard (0xFF), then waits for the ACK (0xFA) and BAT-pass (0xAA) responses before decoding. It sits between the PS/2 transceiver and the NES controller shift-register emulation.

---
 rtl/ps2_keypad_decoder.sv | 149 ++++++++++++++
 tb/tb_ps2_keypad_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_keypad_decoder.sv
// ps2_keypad_decoder: PS/2 set-2 scan codes to a registered NES button vector, with a keyboard reset handshake at start-up
// Ports:
//   i_clk, i_rstn                     clock, asynchronous active-low reset
//   i_scan_val, i_scancode            received byte from the transceiver (level valid)
//   i_ready                           transceiver can accept a command
//   o_cmd_val, o_cmd                  one-cycle command strobe, command byte 0xFF
//   o_buttons                         [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right, 1=pressed
//   o_key_evt                         pulse on the cycle o_buttons changes
//   o_init_done, o_kbd_ok             init finished, keyboard answered BAT pass
module ps2_keypad_decoder #(
  parameter int POWERUP_CYC      = 24000,
  parameter int RESP_TIMEOUT_CYC = 2400000,
  parameter int MAX_RETRY        = 3
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_scan_val,
  input  logic [7:0] i_scancode,
  input  logic       i_ready,
  output logic       o_cmd_val,
  output logic [7:0] o_cmd,
  output logic [7:0] o_buttons,
  output logic       o_key_evt,
  output logic       o_init_done,
  output logic       o_kbd_ok
);
  typedef enum logic [2:0] {WAIT_PWR, SEND, WAIT_ACK, WAIT_BAT, RUN} state_e;
  localparam logic [23:0] PWR_LAST = 24'(POWERUP_CYC - 1);
  localparam logic [23:0] TMO      = 24'(RESP_TIMEOUT_CYC);
  localparam logic [7:0]  MR       = 8'(MAX_RETRY);
  state_e      state_q;
  logic [23:0] cnt_q;
  logic [7:0]  retry_q, retry_d, buttons_q, buttons_d;
  logic        scan_q, ext_q, brk_q, ext_d, brk_d;
  logic        key_evt_q, cmd_val_q, init_done_q, kbd_ok_q;
  logic        evt, timeout, hit;
  logic [2:0]  idx;
  assign evt       = i_scan_val & ~scan_q;
  // A BAT-fail byte ends the wait just like running out of time
  assign timeout   = (cnt_q == TMO) || (state_q == WAIT_BAT && evt && i_scancode == 8'hFC);
  assign retry_d   = retry_q + 8'd1;
  assign o_cmd     = 8'hFF;
  assign o_cmd_val = cmd_val_q;
  assign o_buttons = buttons_q;
  assign o_key_evt = key_evt_q;
  assign o_init_done = init_done_q;
  assign o_kbd_ok  = kbd_ok_q;
  always_comb begin
    idx = 3'd0;
    hit = 1'b1;
    if (!ext_q)
      case (i_scancode)
        8'h42: idx = 3'd0;
        8'h3B: idx = 3'd1;
        8'h2B: idx = 3'd2;
        8'h5A: idx = 3'd3;
        8'h1D: idx = 3'd4;
        8'h1B: idx = 3'd5;
        8'h1C: idx = 3'd6;
        8'h23: idx = 3'd7;
        default: hit = 1'b0;
      endcase
    else
      case (i_scancode)
        8'h5A: idx = 3'd3;
        8'h75: idx = 3'd4;
        8'h72: idx = 3'd5;
        8'h6B: idx = 3'd6;
        8'h74: idx = 3'd7;
        default: hit = 1'b0;
      endcase
  end
  // Prefix bytes keep the other flag; every terminating byte clears both
  always_comb begin
    buttons_d = buttons_q;
    ext_d = 1'b0;
    brk_d = 1'b0;
    if (i_scancode == 8'hE0) begin
      ext_d = 1'b1;
      brk_d = brk_q;
    end else if (i_scancode == 8'hF0) begin
      ext_d = ext_q;
      brk_d = 1'b1;
    end else if (i_scancode == 8'hFA) begin
      ext_d = ext_q;
      brk_d = brk_q;
    end else if (i_scancode == 8'hAA || i_scancode == 8'h00 || i_scancode == 8'hFF || i_scancode == 8'hFE)
      buttons_d = 8'h00;
    else if (hit)
      buttons_d[idx] = ~brk_q;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= WAIT_PWR;
      cnt_q       <= '0;
      retry_q     <= '0;
      scan_q      <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      buttons_q   <= '0;
      key_evt_q   <= 1'b0;
      cmd_val_q   <= 1'b0;
      init_done_q <= 1'b0;
      kbd_ok_q    <= 1'b0;
    end else begin
      scan_q    <= i_scan_val;
      cmd_val_q <= 1'b0;
      key_evt_q <= 1'b0;
      case (state_q)
        WAIT_PWR:
          if (cnt_q == PWR_LAST) begin
            state_q <= SEND;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 24'd1;
        SEND:
          if (i_ready) begin
            cmd_val_q <= 1'b1;
            state_q   <= WAIT_ACK;
            cnt_q     <= '0;
          end
        WAIT_ACK, WAIT_BAT:
          if (state_q == WAIT_ACK && evt && i_scancode == 8'hFA) begin
            state_q <= WAIT_BAT;
            cnt_q   <= '0;
          end else if (state_q == WAIT_BAT && evt && i_scancode == 8'hAA) begin
            state_q     <= RUN;
            kbd_ok_q    <= 1'b1;
            init_done_q <= 1'b1;
          end else if (timeout) begin
            retry_q <= retry_d;
            cnt_q   <= '0;
            if (retry_d < MR) state_q <= SEND;
            else begin
              state_q     <= RUN;
              init_done_q <= 1'b1;
            end
          end else cnt_q <= cnt_q + 24'd1;
        RUN:
          if (evt) begin
            buttons_q <= buttons_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            key_evt_q <= buttons_d != buttons_q;
          end
        default: state_q <= WAIT_PWR;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// tb_ps2_keypad_decoder: randomized scan-code stream checked against a table-driven button model
module tb_ps2_keypad_decoder;
  localparam int PWR = 16, TMO = 100, MR = 3;
  localparam logic [7:0] NMAP[8] = '{8'h42, 8'h3B, 8'h2B, 8'h5A, 8'h1D, 8'h1B, 8'h1C, 8'h23};
  localparam logic [7:0] XMAP[8] = '{8'h00, 8'h00, 8'h00, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74};
  localparam logic [7:0] POOL[22] = '{8'h42, 8'h3B, 8'h2B, 8'h5A, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72,
                                      8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hFA, 8'hAA, 8'h00, 8'hFF,
                                      8'hFE, 8'h15};
  logic clk = 0, rstn = 0, scan_val = 0, ready = 1;
  logic [7:0] code = 0;
  logic cmd_val, key_evt, init_done, kbd_ok;
  logic [7:0] cmd, buttons;
  int total = 0, bad = 0, evt_n = 0, cmd_n = 0, dbl = 0, k, n0;
  logic prev_cmd = 0;
  logic [7:0] exp_b = 0;
  bit m_ext = 0, m_brk = 0;

  ps2_keypad_decoder #(.POWERUP_CYC(PWR), .RESP_TIMEOUT_CYC(TMO), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_scan_val(scan_val), .i_scancode(code), .i_ready(ready),
    .o_cmd_val(cmd_val), .o_cmd(cmd), .o_buttons(buttons), .o_key_evt(key_evt),
    .o_init_done(init_done), .o_kbd_ok(kbd_ok));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (key_evt) evt_n++;
    if (cmd_val) cmd_n++;
    if (cmd_val && prev_cmd) dbl++;
    prev_cmd = cmd_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int map_bit(input bit e, input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      if (e ? (XMAP[i] != 8'h00 && XMAP[i] == b) : NMAP[i] == b) return i;
    return -1;
  endfunction

  task automatic model(input logic [7:0] b);
    int i;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hFA) ;
    else begin
      if (b == 8'hAA || b == 8'h00 || b == 8'hFF || b == 8'hFE) exp_b = 0;
      else begin
        i = map_bit(m_ext, b);
        if (i >= 0) exp_b[i] = !m_brk;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic put(input logic [7:0] b, input int hold);
    @(negedge clk);
    code = b;
    scan_val = 1;
    repeat (hold) @(negedge clk);
    scan_val = 0;
    code = 8'($urandom);
    repeat (2) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] b, input int hold);
    int e0;
    logic [7:0] old;
    e0 = evt_n;
    old = exp_b;
    model(b);
    put(b, hold);
    #1;
    chk("buttons", buttons, exp_b);
    chk("key_evt", evt_n - e0, {31'd0, old != exp_b});
  endtask

  task automatic wait_cmd(output int cyc);
    int base;
    base = cmd_n;
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      #1;
      if (cmd_n != base) break;
    end
    chk("cmd_seen", cmd_n - base, 1);
  endtask

  task automatic handshake;
    put(8'hFA, 3);
    put(8'hAA, 3);
    #1;
    chk("init_done", init_done, 1);
    chk("kbd_ok", kbd_ok, 1);
    exp_b = 0;
    m_ext = 0;
    m_brk = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_buttons", buttons, 0);
    chk("rst_cmd_val", cmd_val, 0);
    chk("rst_cmd", cmd, 8'hFF);
    chk("rst_key_evt", key_evt, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_kbd_ok", kbd_ok, 0);
    rstn = 1;
    wait_cmd(k);
    chk("pwr_latency", k, PWR + 1);
    chk("cmd_byte", cmd, 8'hFF);
    @(negedge clk);
    #1;
    chk("cmd_one_cycle", cmd_val, 0);
    handshake();

    key(8'h42, 5);
    chk("k_press", buttons, 8'h01);
    key(8'hF0, 5);
    key(8'h42, 5);
    chk("k_release", buttons, 8'h00);
    key(8'hE0, 5); key(8'h75, 5);
    chk("up_arrow", buttons, 8'h10);
    key(8'hE0, 5); key(8'h6B, 5);
    chk("left_arrow", buttons, 8'h50);
    key(8'hE0, 5); key(8'hF0, 5); key(8'h75, 5);
    chk("up_release", buttons, 8'h40);
    key(8'h5A, 3); key(8'h1C, 3);
    chk("enter_a", buttons, 8'h48);
    key(8'hFF, 3);
    chk("overrun_clear", buttons, 8'h00);
    key(8'h1D, 2);
    key(8'h15, 2);
    chk("unmapped", buttons, 8'h10);
    key(8'hE0, 2); key(8'hF0, 2); key(8'h72, 2);
    key(8'h1D, 2);
    key(8'hE0, 2); key(8'hF0, 2); key(8'h75, 2);
    chk("alias_last_wins", buttons, 8'h00);

    for (int i = 0; i < 300; i++)
      key(($urandom_range(0, 7) == 0) ? 8'($urandom) : POOL[$urandom_range(0, 21)], $urandom_range(1, 4));

    key(8'hFE, 2); key(8'h5A, 2); key(8'h1C, 2);
    @(negedge clk);
    #2 rstn = 0;
    #1;
    chk("async_buttons", buttons, 0);
    chk("async_init_done", init_done, 0);
    chk("async_kbd_ok", kbd_ok, 0);
    @(negedge clk);
    rstn = 1;
    wait_cmd(k);
    chk("pwr_latency2", k, PWR + 1);
    put(8'hFA, 2);
    n0 = cmd_n;
    put(8'hFC, 1);
    #1;
    chk("bat_fail_retry", cmd_n - n0, 1);
    chk("bat_fail_not_done", init_done, 0);
    handshake();

    @(negedge clk);
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    n0 = cmd_n;
    for (int i = 0; i < 1000 && !init_done; i++) @(negedge clk);
    #1;
    chk("giveup_done", init_done, 1);
    chk("giveup_pulses", cmd_n - n0, MR);
    chk("giveup_kbd_ok", kbd_ok, 0);
    chk("no_double_cmd", dbl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
